neuron_scheduler: RTL and testbench

Time-multiplexed controller for a layer of leaky integrate-and-fire neurons sharing one membrane-update datapath. On each timestep it walks neuron indices 0..N_NEURONS-1 in order. For each neuron it fetches the post-synaptic current over a request/valid handshake, applies leak, integration and threshold, stores the state, and emits a spike event. It sits between the synapse/weight stage, which supplies currents, and the spike router, which consumes spike events. It also resolves the saturation behaviour the single-neuron datapath leaves open.

---
 rtl/neuron_scheduler.sv | 120 ++++++++++++
 tb/tb_neuron_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer controller.
// Walks all neurons once per timestep through one shared update path.
module neuron_scheduler #(
    parameter int N_NEURONS   = 8,
    parameter int IDX_W       = 3,
    parameter int W           = 8,
    parameter int THRESH_INIT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_threshold,
    output logic             cur_req,
    output logic [IDX_W-1:0] cur_idx,
    input  logic             cur_valid,
    input  logic [W-1:0]     cur_data,
    output logic             spike_out,
    output logic [IDX_W-1:0] spike_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UPDATE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [W-1:0]     vmem [N_NEURONS];
    logic             spk  [N_NEURONS];
    logic [W-1:0]     thr;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     cur_q;

    logic [W-1:0]     leak;
    logic [W:0]       sum;
    logic [W-1:0]     new_v;
    logic             fire;

    // A neuron that just fired restarts from a clean integration.
    always_comb begin
        leak  = spk[idx] ? '0 : (vmem[idx] >> 1);
        sum   = {1'b0, cur_q} + {1'b0, leak};
        new_v = sum[W] ? '1 : sum[W-1:0];
        fire  = (new_v >= thr);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH:  if (cur_valid) state_d = UPDATE;
            UPDATE: state_d = (idx == LAST) ? DONE : FETCH;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            thr       <= W'(THRESH_INIT);
            cur_q     <= '0;
            spike_out <= 1'b0;
            spike_idx <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                vmem[i] <= '0;
                spk[i]  <= 1'b0;
            end
        end else begin
            spike_out <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        idx <= '0;
                    end else if (clear) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            vmem[i] <= '0;
                            spk[i]  <= 1'b0;
                        end
                    end else if (cfg_we) begin
                        thr <= cfg_threshold;
                    end
                end
                FETCH: begin
                    if (cur_valid) cur_q <= cur_data;
                end
                UPDATE: begin
                    vmem[idx] <= new_v;
                    spk[idx]  <= fire;
                    spike_out <= fire;
                    spike_idx <= idx;
                    if (idx != LAST) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cur_req = (state_q == FETCH);
    assign cur_idx = idx;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler: timesteps, saturation,
// back-pressure, command gating and asynchronous reset.
module tb_neuron_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_threshold = '0;
    logic       cur_req;
    logic [2:0] cur_idx;
    logic       cur_valid = 1'b0;
    logic [7:0] cur_data = '0;
    logic       spike_out;
    logic [2:0] spike_idx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    neuron_scheduler dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .clear(clear),
        .cfg_we(cfg_we),
        .cfg_threshold(cfg_threshold),
        .cur_req(cur_req),
        .cur_idx(cur_idx),
        .cur_valid(cur_valid),
        .cur_data(cur_data),
        .spike_out(spike_out),
        .spike_idx(spike_idx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_states(input string tag, input logic [7:0] v);
        for (int i = 0; i < 8; i++) chk(tag, dut.vmem[i], v);
    endtask

    task automatic idle_cmd(input bit c, input bit w, input logic [7:0] t);
        @(negedge clk);
        clear = c;
        cfg_we = w;
        cfg_threshold = t;
        @(posedge clk);
        #1;
        clear = 1'b0;
        cfg_we = 1'b0;
    endtask

    // One timestep; cur_valid withheld dly cycles for neuron dly_idx.
    task automatic step(input string tag, input logic [7:0] cur,
                        input int dly_idx, input int dly, input bit poke,
                        input logic [7:0] exp_spk, input int exp_lat,
                        input logic [7:0] exp_st);
        int cyc;
        int lat;
        int waited;
        int held;
        int last;
        bit upd_chk;
        logic [7:0] spikes;
        lat = 999;
        waited = 0;
        held = 0;
        last = -1;
        upd_chk = 0;
        spikes = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            if (poke && cyc == 5) begin
                start = 1'b1;
                clear = 1'b1;
                cfg_we = 1'b1;
                cfg_threshold = 8'd10;
            end else begin
                start = 1'b0;
                clear = 1'b0;
                cfg_we = 1'b0;
            end
            if (upd_chk) begin
                chk({tag, "_bp_upd"}, cur_req, 0);
                upd_chk = 0;
            end
            if (spike_out) begin
                chk({tag, "_spk_ord"}, int'(spike_idx), last + 1);
                last = int'(spike_idx);
                spikes[spike_idx] = 1'b1;
            end
            cur_valid = 1'b0;
            if (cur_req) begin
                if (int'(cur_idx) == dly_idx) held++;
                if (int'(cur_idx) == dly_idx && waited < dly) begin
                    waited++;
                end else begin
                    cur_valid = 1'b1;
                    cur_data = cur;
                    if (int'(cur_idx) == dly_idx) upd_chk = 1;
                end
            end
            if (done) begin
                lat = cyc;
                break;
            end
        end
        start = 1'b0;
        clear = 1'b0;
        cfg_we = 1'b0;
        cur_valid = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_spk"}, spikes, exp_spk);
        if (dly_idx >= 0) chk({tag, "_held"}, held, dly + 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk_states({tag, "_st"}, exp_st);
    endtask

    initial begin
        #12;
        chk("rst_req", cur_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spk", spike_out, 0);
        chk("rst_thr", dut.thr, 32);
        chk_states("rst_st", 8'd0);
        @(negedge clk);
        reset = 1'b0;

        step("ts1", 8'd20, -1, 0, 0, 8'h00, 17, 8'd20);
        step("ts2", 8'd20, -1, 0, 0, 8'h00, 17, 8'd30);
        step("ts3", 8'd20, -1, 0, 0, 8'hff, 17, 8'd35);
        step("ts4", 8'd20, -1, 0, 0, 8'h00, 17, 8'd20);

        idle_cmd(1'b1, 1'b0, 8'd0);
        idle_cmd(1'b0, 1'b1, 8'd255);
        step("sat1", 8'd200, -1, 0, 0, 8'h00, 17, 8'd200);
        step("sat2", 8'd250, -1, 0, 0, 8'hff, 17, 8'd255);
        idle_cmd(1'b0, 1'b1, 8'd32);
        chk("thr_back", dut.thr, 32);

        idle_cmd(1'b1, 1'b0, 8'd0);
        step("bp", 8'd20, 2, 3, 0, 8'h00, 20, 8'd20);

        step("gate", 8'd12, -1, 0, 1, 8'h00, 17, 8'd22);
        chk("gate_thr", dut.thr, 32);
        idle_cmd(1'b0, 1'b1, 8'd10);
        step("cfg10", 8'd12, -1, 0, 0, 8'hff, 17, 8'd23);

        idle_cmd(1'b1, 1'b0, 8'd0);
        chk_states("clr_st", 8'd0);
        chk("clr_spk0", dut.spk[0], 0);
        step("clr5", 8'd5, -1, 0, 0, 8'h00, 17, 8'd5);

        idle_cmd(1'b0, 1'b1, 8'd0);
        step("thr0", 8'd0, -1, 0, 0, 8'hff, 17, 8'd2);

        // Abort a timestep while neuron 1 is being fetched.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        cur_valid = 1'b1;
        cur_data = 8'd0;
        @(negedge clk);
        cur_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_req", cur_req, 1);
        chk("ar_pre_spk", spike_out, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_req", cur_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_spk", spike_out, 0);
        chk("ar_done", done, 0);
        chk("ar_thr", dut.thr, 32);
        chk_states("ar_st", 8'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            chk("ar_no_done", seen, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
